pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_pkg.sv | 6 +
 rtl/pipe_cell.sv | 30 +++
 rtl/pipe_reg.sv | 85 ++++++++
 tb/tb_pipe_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the stall/flush pipeline register and its stage cells.
package pipe_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int CNT_W_DEFAULT  = 16;
  localparam int MAX_DEPTH      = 4;
endpackage

// File: rtl/pipe_cell.sv
// One pipeline stage: a valid bit plus a payload that only loads real items.
module pipe_cell
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              upVal,
  input  logic [DATA_W-1:0] upData,
  output logic              val,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      val  <= 1'b0;
      data <= '0;
    end else if (flush) begin
      val <= 1'b0;
    end else if (en) begin
      val <= upVal;
      // bubbles move forward without disturbing the last payload
      if (upVal) data <= upData;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Multi-stage pipeline register with hazard stall, flush, bubble collapsing
// and saturating stall/bubble statistics.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hazard,
  input  logic              flush,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              inReady,
  output logic              outValid,
  output logic [DATA_W-1:0] outData,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  bubbleCount
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("pipe_reg: DEPTH must be in 1..%0d", MAX_DEPTH);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  logic [DEPTH-1:0]  stage_val;
  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]  en;
  logic              chain;

  // Enable ripples from the output back to the input: an empty stage always
  // accepts, a full one only when everything downstream moves.
  always_comb begin
    en    = '0;
    chain = !hazard;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      en[k] = !stage_val[k] || chain;
      chain = en[k];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              up_val;
    logic [DATA_W-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_val  = inValid;
      assign up_data = inData;
    end else begin : g_body
      assign up_val  = stage_val[k-1];
      assign up_data = stage_data[k-1];
    end

    pipe_cell #(.DATA_W(DATA_W)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .en     (en[k]),
      .flush  (flush),
      .upVal  (up_val),
      .upData (up_data),
      .val    (stage_val[k]),
      .data   (stage_data[k])
    );
  end

  assign inReady  = en[0];
  assign outValid = stage_val[DEPTH-1];
  assign outData  = stage_data[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCount  <= '0;
      bubbleCount <= '0;
    end else begin
      if (hazard && outValid && !flush) stallCount <= sat_inc(stallCount);
      if (!outValid) bubbleCount <= sat_inc(bubbleCount);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed and queue-scoreboard bench for pipe_reg across several depths.
module tb_pipe_reg;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance a: DEPTH=2
  logic a_reset, a_hazard, a_flush, a_inValid, a_inReady, a_outValid;
  logic [31:0] a_inData, a_outData;
  logic [15:0] a_stall, a_bubble;
  // instance b: DEPTH=3, CNT_W=4
  logic b_reset, b_hazard, b_flush, b_inValid, b_inReady, b_outValid;
  logic [31:0] b_inData, b_outData;
  logic [3:0]  b_stall, b_bubble;
  // instance c: DEPTH=4
  logic c_reset, c_hazard, c_flush, c_inValid, c_inReady, c_outValid;
  logic [31:0] c_inData, c_outData;
  logic [15:0] c_stall, c_bubble;
  // instance d: DEPTH=1
  logic d_reset, d_hazard, d_flush, d_inValid, d_inReady, d_outValid;
  logic [31:0] d_inData, d_outData;
  logic [15:0] d_stall, d_bubble;

  pipe_reg #(.DATA_W(32), .DEPTH(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(a_reset), .hazard(a_hazard), .flush(a_flush),
    .inValid(a_inValid), .inData(a_inData), .inReady(a_inReady),
    .outValid(a_outValid), .outData(a_outData),
    .stallCount(a_stall), .bubbleCount(a_bubble));

  pipe_reg #(.DATA_W(32), .DEPTH(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(b_reset), .hazard(b_hazard), .flush(b_flush),
    .inValid(b_inValid), .inData(b_inData), .inReady(b_inReady),
    .outValid(b_outValid), .outData(b_outData),
    .stallCount(b_stall), .bubbleCount(b_bubble));

  pipe_reg #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) u_c (
    .clk(clk), .reset(c_reset), .hazard(c_hazard), .flush(c_flush),
    .inValid(c_inValid), .inData(c_inData), .inReady(c_inReady),
    .outValid(c_outValid), .outData(c_outData),
    .stallCount(c_stall), .bubbleCount(c_bubble));

  pipe_reg #(.DATA_W(32), .DEPTH(1), .CNT_W(16)) u_d (
    .clk(clk), .reset(d_reset), .hazard(d_hazard), .flush(d_flush),
    .inValid(d_inValid), .inData(d_inData), .inReady(d_inReady),
    .outValid(d_outValid), .outData(d_outData),
    .stallCount(d_stall), .bubbleCount(d_bubble));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_item;

  initial begin
    {a_reset, a_hazard, a_flush, a_inValid} = '0; a_inData = '0;
    {b_reset, b_hazard, b_flush, b_inValid} = '0; b_inData = '0;
    {c_reset, c_hazard, c_flush, c_inValid} = '0; c_inData = '0;
    {d_reset, d_hazard, d_flush, d_inValid} = '0; d_inData = '0;

    step();
    chk("a_rst_outValid", a_outValid, 0);
    chk("a_rst_outData",  a_outData, 0);
    chk("a_rst_inReady",  a_inReady, 1);
    chk("a_rst_stall",    a_stall, 0);
    chk("a_rst_bubble",   a_bubble, 0);

    // DEPTH=2 latency and ordering
    a_reset = 1; a_inValid = 1; a_inData = 32'hA000_0001;
    step();
    chk("a_lat_not_yet", a_outValid, 0);
    a_inData = 32'hA000_0002;
    step();
    chk("a_out1_valid", a_outValid, 1);
    chk("a_out1_data",  a_outData, 32'hA000_0001);
    a_inData = 32'hA000_0003;
    step();
    chk("a_out2_data", a_outData, 32'hA000_0002);
    a_inValid = 0;
    step();
    chk("a_out3_data", a_outData, 32'hA000_0003);
    step();
    chk("a_drained", a_outValid, 0);
    chk("a_bubble2", a_bubble, 2);

    // DEPTH=2 fill under hazard, then flush while stalled
    a_inValid = 1; a_hazard = 1; a_inData = 32'hB1;
    step();
    a_inData = 32'hB2;
    step();
    chk("a_full_valid",   a_outValid, 1);
    chk("a_full_data",    a_outData, 32'hB1);
    chk("a_full_inReady", a_inReady, 0);
    chk("a_full_stall",   a_stall, 0);
    a_inData = 32'hB3;
    step();
    chk("a_stall1",      a_stall, 1);
    chk("a_stall_hold",  a_outData, 32'hB1);
    a_flush = 1;
    step();
    chk("a_flush_valid",   a_outValid, 0);
    chk("a_flush_inReady", a_inReady, 1);
    chk("a_flush_stall",   a_stall, 1);
    chk("a_flush_data",    a_outData, 32'hB1);
    a_flush = 0; a_hazard = 0; a_inValid = 0;

    // DEPTH=3 bubble collapsing under hazard, stall saturation at CNT_W=4
    b_reset = 1; b_inValid = 1; b_inData = 32'h99;
    step();
    b_inValid = 0;
    step();
    step();
    chk("b_pre_valid", b_outValid, 1);
    chk("b_pre_data",  b_outData, 32'h99);
    b_hazard = 1; b_inValid = 1; b_inData = 32'h11;
    #1;
    chk("b_ready_1st", b_inReady, 1);
    step();
    chk("b_hold1_data", b_outData, 32'h99);
    chk("b_ready_2nd",  b_inReady, 1);
    b_inData = 32'h22;
    step();
    b_inData = 32'h33;
    #1;
    chk("b_ready_3rd",  b_inReady, 0);
    chk("b_hold2_data", b_outData, 32'h99);
    chk("b_stall2",     b_stall, 2);
    b_inValid = 0;
    repeat (13) step();
    chk("b_stall_sat", b_stall, 15);
    repeat (5) step();
    chk("b_stall_nowrap", b_stall, 15);
    chk("b_hold3_data",   b_outData, 32'h99);
    b_hazard = 0;
    step();
    chk("b_rel1_valid", b_outValid, 1);
    chk("b_rel1_data",  b_outData, 32'h11);
    step();
    chk("b_rel2_data",  b_outData, 32'h22);
    step();
    chk("b_rel_empty",  b_outValid, 0);

    // DEPTH=4 reset mid-operation overrides hazard/flush/inValid
    c_reset = 1; c_inValid = 1;
    for (int i = 0; i < 4; i++) begin
      c_inData = 32'hD0 + i;
      step();
    end
    chk("c_full_valid", c_outValid, 1);
    chk("c_full_data",  c_outData, 32'hD0);
    c_hazard = 1; c_flush = 1; c_inData = 32'h55; c_reset = 0;
    step();
    chk("c_rst_valid",   c_outValid, 0);
    chk("c_rst_data",    c_outData, 0);
    chk("c_rst_stall",   c_stall, 0);
    chk("c_rst_bubble",  c_bubble, 0);
    chk("c_rst_inReady", c_inReady, 1);
    c_reset = 1; c_hazard = 0; c_flush = 0; c_inValid = 0;
    step();
    chk("c_rel_valid",   c_outValid, 0);
    chk("c_rel_inReady", c_inReady, 1);
    chk("c_rel_bubble1", c_bubble, 1);
    step();
    chk("c_rel_bubble2", c_bubble, 2);

    // DEPTH=1 random traffic against a FIFO scoreboard
    d_reset = 1;
    for (int n = 0; n < 10000; n++) begin
      d_hazard  = ($urandom_range(0, 9) < 3);
      d_flush   = ($urandom_range(0, 19) == 0);
      d_inValid = ($urandom_range(0, 9) < 7);
      d_inData  = $urandom;
      #1;
      if (d_flush) begin
        q.delete();
      end else begin
        if (d_outValid && !d_hazard) begin
          if (q.size() == 0) begin
            chk("d_spurious_valid", d_outValid, 1'b0);
          end else begin
            exp_item = q.pop_front();
            chk("d_order", d_outData, exp_item);
          end
        end
        if (d_inValid && d_inReady) q.push_back(d_inData);
      end
      step();
      chk("d_valid", d_outValid, q.size() != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
